// File: rtl/cam_pkg.sv
// Shared constants, command encoding and helpers for the pipelined CAM.
package cam_pkg;

  localparam int unsigned CAM_WIDTH    = 48;
  localparam int unsigned CAM_NUMWORDS = 128;
  localparam int unsigned CAM_WIDTHAD  = 7;

  typedef enum logic [2:0] {
    CMD_SEARCH = 3'd0,
    CMD_MASK   = 3'd1,
    CMD_ERASE  = 3'd2,
    CMD_WRITE  = 3'd3,
    CMD_WRDC   = 3'd4
  } cmd_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/cam_prio_enc.sv
// Combinational lowest-index priority encoder with any-set and multi-set flags.
module cam_prio_enc
  import cam_pkg::*;
#(
  parameter int unsigned NUMWORDS = CAM_NUMWORDS,
  parameter int unsigned WIDTHAD  = CAM_WIDTHAD
) (
  input  logic [NUMWORDS-1:0] vec,
  output logic [WIDTHAD-1:0]  idx_c,
  output logic                any_c,
  output logic                multi_c
);

  always_comb begin
    idx_c   = '0;
    any_c   = 1'b0;
    multi_c = 1'b0;
    for (int i = 0; i < int'(NUMWORDS); i++) begin
      if (vec[i]) begin
        if (!any_c) idx_c = WIDTHAD'(i);
        multi_c = multi_c | any_c;
        any_c   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cam_search_pipe.sv
// Pipelined ternary CAM: storage, command decode, compare, two result stages.
// Optional MatchCount output enabled by defining CAM_MATCH_COUNT_EN.
module cam_search_pipe
  import cam_pkg::*;
#(
  parameter int unsigned WIDTH    = CAM_WIDTH,
  parameter int unsigned NUMWORDS = CAM_NUMWORDS,
  parameter int unsigned WIDTHAD  = CAM_WIDTHAD
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               ClockEn,
  input  logic [WIDTH-1:0]   Data,
  input  logic [WIDTHAD-1:0] WrAddress,
  input  logic               WE,
  input  logic               WrDC,
  input  logic               Erase,
  input  logic               WrMask,
  input  logic               EnMask,
  output logic [WIDTHAD-1:0] Address,
  output logic               Match,
  output logic               MulMatch,
  output logic               SearchValid
`ifdef CAM_MATCH_COUNT_EN
  ,
  output logic [WIDTHAD:0]   MatchCount
`endif
);

  localparam int unsigned CW = WIDTHAD + 1;

  cmd_e                cmd;
  logic                addr_ok;
  logic [WIDTH-1:0]    entry_q [NUMWORDS];
  logic [WIDTH-1:0]    dc_q    [NUMWORDS];
  logic [NUMWORDS-1:0] valid_q;
  logic [WIDTH-1:0]    mask_q;
  logic [WIDTH-1:0]    care;
  logic [NUMWORDS-1:0] match_vec;
  logic                s1_valid_q;
  logic [NUMWORDS-1:0] s1_vec_q;
  logic [WIDTHAD-1:0]  pe_idx;
  logic                pe_any;
  logic                pe_multi;

  always_comb begin
    cmd = CMD_SEARCH;
    if (WrMask)     cmd = CMD_MASK;
    else if (Erase) cmd = CMD_ERASE;
    else if (WE)    cmd = WrDC ? CMD_WRDC : CMD_WRITE;
  end

  // Guards non-power-of-two depths against writes past the last entry.
  assign addr_ok = ({1'b0, WrAddress} < CW'(NUMWORDS));

  // Entry values are deliberately left out of reset.
  always_ff @(posedge Clock) begin
    if (!Reset && ClockEn && cmd == CMD_WRITE && addr_ok)
      entry_q[WrAddress] <= Data;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      valid_q <= '0;
      mask_q  <= '1;
      for (int i = 0; i < int'(NUMWORDS); i++) dc_q[i] <= '0;
    end else if (ClockEn) begin
      case (cmd)
        CMD_MASK:  mask_q <= Data;
        CMD_ERASE: if (addr_ok) valid_q[WrAddress] <= 1'b0;
        CMD_WRITE: if (addr_ok) valid_q[WrAddress] <= 1'b1;
        CMD_WRDC:  if (addr_ok) dc_q[WrAddress] <= Data;
        default: ;
      endcase
    end
  end

  always_comb begin
    care = EnMask ? mask_q : '1;
    for (int i = 0; i < int'(NUMWORDS); i++)
      match_vec[i] = valid_q[i] && (((entry_q[i] ^ Data) & ~dc_q[i] & care) == '0);
  end

  // Stage 1: match vector; command cycles become bubbles with an empty vector.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      s1_valid_q <= 1'b0;
      s1_vec_q   <= '0;
    end else if (ClockEn) begin
      s1_valid_q <= (cmd == CMD_SEARCH);
      s1_vec_q   <= (cmd == CMD_SEARCH) ? match_vec : '0;
    end
  end

  cam_prio_enc #(
    .NUMWORDS (NUMWORDS),
    .WIDTHAD  (WIDTHAD)
  ) u_prio_enc (
    .vec     (s1_vec_q),
    .idx_c   (pe_idx),
    .any_c   (pe_any),
    .multi_c (pe_multi)
  );

  // Stage 2: registered search result.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      Address     <= '0;
      Match       <= 1'b0;
      MulMatch    <= 1'b0;
      SearchValid <= 1'b0;
    end else if (ClockEn) begin
      Address     <= pe_idx;
      Match       <= pe_any;
      MulMatch    <= pe_multi;
      SearchValid <= s1_valid_q;
    end
  end

`ifdef CAM_MATCH_COUNT_EN
  logic [WIDTHAD:0] pop;

  always_comb begin
    pop = '0;
    for (int i = 0; i < int'(NUMWORDS); i++) pop = pop + CW'(s1_vec_q[i]);
  end

  always_ff @(posedge Clock) begin
    if (Reset)        MatchCount <= '0;
    else if (ClockEn) MatchCount <= pop;
  end
`endif

endmodule

// File: tb/tb_cam_search_pipe.sv
// Directed self-checking bench for cam_search_pipe (default parameters).
module tb_cam_search_pipe;

  logic        Clock;
  logic        Reset;
  logic        ClockEn;
  logic [47:0] Data;
  logic [6:0]  WrAddress;
  logic        WE;
  logic        WrDC;
  logic        Erase;
  logic        WrMask;
  logic        EnMask;
  logic [6:0]  Address;
  logic        Match;
  logic        MulMatch;
  logic        SearchValid;
`ifdef CAM_MATCH_COUNT_EN
  logic [7:0]  MatchCount;
`endif

  int n_cmp;
  int n_bad;

  cam_search_pipe #(
    .WIDTH    (48),
    .NUMWORDS (128),
    .WIDTHAD  (7)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .ClockEn     (ClockEn),
    .Data        (Data),
    .WrAddress   (WrAddress),
    .WE          (WE),
    .WrDC        (WrDC),
    .Erase       (Erase),
    .WrMask      (WrMask),
    .EnMask      (EnMask),
    .Address     (Address),
    .Match       (Match),
    .MulMatch    (MulMatch),
    .SearchValid (SearchValid)
`ifdef CAM_MATCH_COUNT_EN
    ,
    .MatchCount  (MatchCount)
`endif
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clock);
    #1;
  endtask

  task automatic command(input logic we, input logic wrdc, input logic erase,
                         input logic wrmask, input logic [6:0] addr, input logic [47:0] d);
    WE = we; WrDC = wrdc; Erase = erase; WrMask = wrmask;
    WrAddress = addr; Data = d;
    cyc();
    WE = 1'b0; WrDC = 1'b0; Erase = 1'b0; WrMask = 1'b0;
  endtask

  task automatic search(input logic [47:0] key, input logic en);
    Data = key; EnMask = en;
    cyc();
    cyc();
  endtask

  task automatic expect_res(input string tag, input logic m, input logic [6:0] a, input logic mm);
    check({tag, ".valid"}, 32'(SearchValid), 32'd1);
    check({tag, ".match"}, 32'(Match), 32'(m));
    check({tag, ".addr"},  32'(Address), 32'(a));
    check({tag, ".mul"},   32'(MulMatch), 32'(mm));
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    Reset = 1'b1; ClockEn = 1'b1; Data = '0; WrAddress = '0;
    WE = 1'b0; WrDC = 1'b0; Erase = 1'b0; WrMask = 1'b0; EnMask = 1'b0;
    cyc(); cyc();
    check("rst.valid", 32'(SearchValid), 32'd0);
    check("rst.match", 32'(Match), 32'd0);
    check("rst.addr",  32'(Address), 32'd0);
    check("rst.mul",   32'(MulMatch), 32'd0);
`ifdef CAM_MATCH_COUNT_EN
    check("rst.count", 32'(MatchCount), 32'd0);
`endif
    Reset = 1'b0;

    command(1'b1, 1'b0, 1'b0, 1'b0, 7'd5, 48'h0000_0000_00AA);
    search(48'h0000_0000_00AA, 1'b0);
    expect_res("single", 1'b1, 7'd5, 1'b0);

    command(1'b1, 1'b0, 1'b0, 1'b0, 7'd3, 48'h1234);
    command(1'b1, 1'b0, 1'b0, 1'b0, 7'd9, 48'h1234);
    search(48'h1234, 1'b0);
    expect_res("multi", 1'b1, 7'd3, 1'b1);
`ifdef CAM_MATCH_COUNT_EN
    check("multi.count", 32'(MatchCount), 32'd2);
`endif

    command(1'b0, 1'b0, 1'b1, 1'b0, 7'd3, 48'h0);
    command(1'b0, 1'b0, 1'b1, 1'b0, 7'd9, 48'h0);
    search(48'h1234, 1'b0);
    expect_res("erased", 1'b0, 7'd0, 1'b0);

    command(1'b0, 1'b0, 1'b0, 1'b1, 7'd0, 48'h0000_0000_FF00);
    command(1'b1, 1'b0, 1'b0, 1'b0, 7'd7, 48'h12AB);
    search(48'h12CD, 1'b1);
    expect_res("mask_on", 1'b1, 7'd7, 1'b0);
    search(48'h12CD, 1'b0);
    expect_res("mask_off", 1'b0, 7'd0, 1'b0);

    command(1'b1, 1'b1, 1'b0, 1'b0, 7'd7, 48'h000F);
    search(48'h12A0, 1'b0);
    expect_res("dc", 1'b1, 7'd7, 1'b0);
    command(1'b0, 1'b0, 1'b1, 1'b0, 7'd7, 48'h0);
    search(48'h12A0, 1'b0);
    expect_res("dc_erase", 1'b0, 7'd0, 1'b0);

    command(1'b1, 1'b0, 1'b0, 1'b0, 7'd1, 48'h1111);
    command(1'b1, 1'b0, 1'b0, 1'b0, 7'd2, 48'h2222);
    EnMask = 1'b0;
    Data = 48'h2222; cyc();
    Data = 48'h00AA; cyc();
    check("pre_stall.addr", 32'(Address), 32'd2);
    ClockEn = 1'b0;
    Data = 48'h3333;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("stall.addr",  32'(Address), 32'd2);
      check("stall.match", 32'(Match), 32'd1);
      check("stall.valid", 32'(SearchValid), 32'd1);
    end
    ClockEn = 1'b1;
    Data = 48'h1111; cyc();
    expect_res("resume_a", 1'b1, 7'd5, 1'b0);
    Data = 48'h3333; cyc();
    expect_res("resume_b", 1'b1, 7'd1, 1'b0);
    cyc();
    expect_res("resume_d", 1'b0, 7'd0, 1'b0);

    Data = 48'h00AA; cyc();
    Reset = 1'b1; cyc();
    check("midrst.valid", 32'(SearchValid), 32'd0);
    check("midrst.match", 32'(Match), 32'd0);
    Reset = 1'b0; cyc();
    check("postrst.valid", 32'(SearchValid), 32'd0);
    cyc();
    expect_res("postrst", 1'b0, 7'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cam_search_pipe.md
# cam_search_pipe

Parametrised, pipelined content-addressable memory; next generation of the team's CAM block. It stores `NUMWORDS` entries of `WIDTH` bits, each with a valid bit and a per-entry don't-care vector. It compares a search key against all entries under a global search mask and returns the lowest matching address, with match and multi-match flags, after a fixed two-cycle latency. It sits between the packet-header parser and the lookup-result logic.

## Interface
Parameters:
- `WIDTH`, default 48: entry and key width in bits.
- `NUMWORDS`, default 128: number of entries; must be at least 2.
- `WIDTHAD`, default 7: address width; must equal clog2(`NUMWORDS`).

Ports:
- `Clock`, in, 1: the single clock; all state updates on its rising edge.
- `Reset`, in, 1: synchronous, active-high reset.
- `ClockEn`, in, 1: global enable; when 0, every register holds, including the pipeline.
- `Data`, in, `WIDTH`: write data, mask data or search key, depending on the command.
- `WrAddress`, in, `WIDTHAD`: target entry for write, don't-care write and erase.
- `WE`, in, 1: write command.
- `WrDC`, in, 1: qualifies `WE`; selects a don't-care vector write instead of a value write.
- `Erase`, in, 1: clears the valid bit of entry `WrAddress`.
- `WrMask`, in, 1: loads the search mask register from `Data`.
- `EnMask`, in, 1: applies the search mask to the current search.
- `Address`, out, `WIDTHAD`: lowest matching entry.
- `Match`, out, 1: at least one entry matched.
- `MulMatch`, out, 1: two or more entries matched.
- `SearchValid`, out, 1: `Address`/`Match`/`MulMatch` carry a search result this cycle.

## Operation
- Command decode happens only in cycles with `ClockEn`=1. Priority is `WrMask` > `Erase` > `WE` > search.
- **Mask load** (`WrMask`=1): mask <= `Data`. Mask bit 1 means the bit participates in the compare.
- **Erase** (`Erase`=1): valid[`WrAddress`] <= 0. Entry contents are unchanged.
- **Value write** (`WE`=1, `WrDC`=0): entry[`WrAddress`] <= `Data`; valid[`WrAddress`] <= 1.
- **Don't-care write** (`WE`=1, `WrDC`=1): dc[`WrAddress`] <= `Data`. dc bit 1 means the bit is ignored for that entry. The valid bit is unchanged.
- **Search**: any enabled cycle with no command above. Entry i matches when valid[i]=1 and, for every bit b where dc[i][b]=0 and (`EnMask`=0 or mask[b]=1), entry[i][b]=`Data`[b].
- **Pipeline stage 1**: registers the `NUMWORDS`-bit match vector and a stage-valid bit.
- **Pipeline stage 2**: priority-encodes the lowest set index and registers `Address`, `Match`, `MulMatch` and `SearchValid`.
- Command cycles inject a bubble: the stage-valid bit is 0 in that slot.
- With no match: `Match`=0, `MulMatch`=0, `Address`=0.

## Timing
- Search latency is 2 enabled cycles. A key sampled at edge N produces its result on the outputs after edge N+2. Throughput is one search per enabled cycle.
- `ClockEn`=0 stalls all stages. Outputs and `SearchValid` hold their last values.
- Write followed by search: a search in the enabled cycle directly after a write/erase/dc/mask command sees the updated state. There is no hazard.
- Reset (synchronous, takes precedence over `ClockEn`):
  - All valid bits cleared; dc vectors cleared to 0; mask set to all ones.
  - Pipeline stage-valid bits cleared.
  - `Address`=0, `Match`=0, `MulMatch`=0, `SearchValid`=0.
  - Entry value storage is not reset.
- Reset mid-search: results in flight are discarded. `SearchValid` is 0 on the cycle after reset.
- Out-of-range `WrAddress` (at or above `NUMWORDS` when it is not a power of two): write, dc write and erase are ignored.

## Configuration
- `CAM_MATCH_COUNT_EN` defined: adds output `MatchCount` [`WIDTHAD`:0]. It is the population count of the match vector, registered in stage 2 and aligned with `SearchValid`; its reset value is 0.
- `CAM_MATCH_COUNT_EN` undefined: the port and the popcount logic are absent. `MulMatch` is still produced by the priority encoder.

## Structure
- Package `cam_pkg`:
  - command encoding enum (`CMD_SEARCH`, `CMD_MASK`, `CMD_ERASE`, `CMD_WRITE`, `CMD_WRDC`);
  - clog2 function;
  - default width/depth constants.
- Sub-module `cam_prio_enc`: parametrised by `NUMWORDS`/`WIDTHAD`. It is combinational and yields the lowest index, any-set and multi-set; stage 2 registers its outputs.
- Storage, decode and compare stay in the top module.

## Test plan
- Reset, write 0x0000_0000_00AA to entry 5, search 0x00AA -> two cycles later `Match`=1, `Address`=5, `MulMatch`=0, `SearchValid`=1.
- Write 0x1234 to entries 3 and 9, search 0x1234 -> `Address`=3, `MulMatch`=1 (with the macro defined, `MatchCount`=2).
- Load mask 0xFF00, entry 7=0x12AB, search 0x12CD with `EnMask`=1 -> match at 7. Same search with `EnMask`=0 -> `Match`=0.
- dc write 0x000F to entry 7, search 0x12A0 with `EnMask`=0 -> match at 7. Erase entry 7, search again -> `Match`=0.
- Back-to-back searches with `ClockEn` dropped for 3 cycles mid-stream -> outputs hold during the stall, and results resume in order with 2-cycle latency counted in enabled cycles.
- Assert `Reset` one cycle after a matching search -> `SearchValid` stays 0, `Match`=0, and a later search of the same key misses.
